// File: rtl/fetch_sequencer.sv
// Program counter and fetch control in front of a one-cycle-latency instruction ROM.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    input  logic        halt,
    output logic [31:0] instrAdd,
    output logic [31:0] pcOut,
    output logic [31:0] pcNext,
    output logic        instrValid,
    output logic        halted,
    output logic [31:0] instrCount
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]        state_q,       state_d;
    logic [ADDR_W-1:0] fetch_pc_q,    fetch_pc_d;
    logic [ADDR_W-1:0] pc_out_q,      pc_out_d;
    logic              instr_valid_q, instr_valid_d;
    logic              halted_q,      halted_d;
    logic [CNT_W-1:0]  instr_count_q, instr_count_d;
    logic [CNT_W-1:0]  count_inc;

    // Retired-instruction count increment, saturating at all ones.
    always_comb begin
        count_inc = instr_count_q;
        if (instr_count_q != {CNT_W{1'b1}}) begin
            count_inc = instr_count_q + CNT_W'(1);
        end
    end

    // ROM address mux; re-reading pcOut keeps the ROM output unchanged.
    always_comb begin
        instrAdd = fetch_pc_q;
        case (state_q)
            ST_IDLE:   instrAdd = RESET_PC;
            ST_HALTED: instrAdd = pc_out_q;
            ST_RUN: begin
                if (stall || halt) begin
                    instrAdd = pc_out_q;
                end else if (redirect) begin
                    instrAdd = redirectTarget;
                end else begin
                    instrAdd = fetch_pc_q;
                end
            end
            default:   instrAdd = RESET_PC;
        endcase
    end

    // Next-state logic: stall beats halt, halt beats redirect.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        instr_count_d = instr_count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_RUN;
                    pc_out_d      = RESET_PC;
                    fetch_pc_d    = RESET_PC + PC_STEP;
                    instr_valid_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (stall) begin
                    state_d = ST_RUN;
                end else if (halt) begin
                    state_d       = ST_HALTED;
                    instr_valid_d = 1'b0;
                    halted_d      = 1'b1;
                end else if (redirect) begin
                    pc_out_d      = redirectTarget;
                    fetch_pc_d    = redirectTarget + PC_STEP;
                    instr_count_d = count_inc;
                end else begin
                    pc_out_d      = fetch_pc_q;
                    fetch_pc_d    = fetch_pc_q + PC_STEP;
                    instr_count_d = count_inc;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d       = ST_IDLE;
                instr_valid_d = 1'b0;
                halted_d      = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC + PC_STEP;
            pc_out_q      <= RESET_PC;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pc_out_q      <= pc_out_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign pcOut      = pc_out_q;
    assign pcNext     = pc_out_q + PC_STEP;
    assign instrValid = instr_valid_q;
    assign halted     = halted_q;
    assign instrCount = instr_count_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and fetch-control stage directly upstream of the instruction memory (registered single-port ROM, one-cycle read latency).
- Drives the ROM address every cycle and tracks which address the current ROM output belongs to.
- Applies stall, branch/jump redirect and halt requests from the datapath.
- Emits an aligned PC, link address, valid flag and retired-instruction count for the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, first instruction address fetched after start.
- PC_STEP, 32'd1, PC increment per instruction (ROM is word-addressed).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; leaves IDLE and begins fetching.
- stall  input  1  hold the current instruction and PC.
- redirect  input  1  taken branch/jump for the instruction at pcOut.
- redirectTarget  input  32  absolute target address when redirect=1.
- halt  input  1  instruction at pcOut is a halt.
- instrAdd  output  32  ROM address, combinational from state and inputs; sampled by ROM on each rising edge.
- pcOut  output  32  address of the instruction currently on the ROM output.
- pcNext  output  32  pcOut + PC_STEP, combinational; link address.
- instrValid  output  1  ROM output holds a live instruction.
- halted  output  1  sequencer is in HALTED.
- instrCount  output  32  count of retired instructions.

Behaviour:
- Reset and clocking:
  - One clock. Reset is synchronous and active-low: rst=0 at a rising edge overrides everything.
  - Reset values: state=IDLE, fetchPc=RESET_PC+PC_STEP, pcOut=RESET_PC, instrValid=0, halted=0, instrCount=0.
  - Reset mid-run (including during stall, redirect or HALTED) gives the same result; the next edge's ROM data is ignored because instrValid=0.
- States: IDLE, RUN, HALTED. Internal register fetchPc holds the next sequential address.
- instrAdd mux, evaluated in priority order:
  - IDLE: RESET_PC.
  - HALTED: pcOut.
  - RUN with stall=1: pcOut (ROM re-reads, so its output is unchanged).
  - RUN with halt=1: pcOut.
  - RUN with redirect=1: redirectTarget.
  - Otherwise: fetchPc.
- Edge actions:
  - IDLE, start=1: pcOut<=RESET_PC, fetchPc<=RESET_PC+PC_STEP, instrValid<=1, go to RUN. The first instruction is valid one cycle after start.
  - IDLE, start=0: hold.
  - RUN, stall=1: all registers hold. Stall beats halt and redirect; the producer keeps redirect/halt asserted until stall drops.
  - RUN, halt=1, stall=0: go to HALTED, instrValid<=0, halted<=1, pcOut held. Halt beats redirect. The halt instruction is not counted.
  - RUN, redirect=1: pcOut<=redirectTarget, fetchPc<=redirectTarget+PC_STEP, instrCount+1. No bubble.
  - RUN, no event: pcOut<=fetchPc, fetchPc<=fetchPc+PC_STEP, instrCount+1.
  - HALTED: ignores start, stall, redirect and halt; only reset exits.
- Latency: address on instrAdd at edge k, instruction and matching pcOut both valid after edge k.
- Arithmetic:
  - All adds are 32-bit modulo, so 32'hFFFF_FFFF+1 = 0 with no error.
  - redirectTarget is used unmodified; no alignment check.
  - instrCount saturates at 32'hFFFF_FFFF.
- start while in RUN or HALTED is ignored.

Test Plan:
- Reset and start: rst=0 for 2 edges, then start pulse → instrAdd=0 in IDLE; after start edge pcOut=0, instrValid=1; after 3 more edges pcOut=3, instrCount=3, pcNext=4.
- Stall: at pcOut=5, stall=1 for 3 cycles → instrAdd=5, pcOut=5, ROM data unchanged, instrCount frozen; stall release → pcOut=6 on the next edge.
- Redirect: at pcOut=7, redirect=1, target=32'h40 for one cycle → instrAdd=32'h40 that cycle; next pcOut=32'h40, then 32'h41. No invalid cycle; count increments each edge.
- Stall with redirect: stall=1, redirect=1 → no PC change. Drop stall while holding redirect → pcOut=target.
- Halt: halt=1 at pcOut=9 → next cycle halted=1, instrValid=0, pcOut=9. Later redirect/start pulses → no change. rst=0 → IDLE with reset values.
- Wrap: redirect to 32'hFFFF_FFFF → next pcOut=32'hFFFF_FFFF, pcNext=0; the following edge gives pcOut=0.
